// File: rtl/pattern_detector_param.sv
// -----------------------------------------------------------------------------
// pattern_detector_param
//
// Parametrised serial Mealy pattern detector. A runtime-loadable PAT_W-bit
// pattern (MSB = first bit received) is matched against a qualified serial
// bit stream. Overlapping or non-overlapping detection is selected per cycle.
// A saturating counter tracks the number of matches.
//
// Ports:
//   clk         in   1      rising-edge clock
//   reset       in   1      asynchronous, active-high; clears all state
//   din_valid   in   1      din is sampled only when 1
//   din         in   1      serial data bit
//   overlap     in   1      1 = overlapping detection, 0 = non-overlapping
//   pat_load    in   1      load pat_in as the new pattern this cycle
//   pat_in      in   PAT_W  new pattern, MSB = first bit
//   count_clr   in   1      synchronous clear of match_count
//   z           out  1      Mealy match flag, combinational from state + inputs
//   match_count out  CNT_W  saturating number of matches
// -----------------------------------------------------------------------------
module pattern_detector_param #(
  parameter int unsigned           PAT_W       = 4,
  parameter int unsigned           CNT_W       = 8,
  parameter logic [PAT_W-1:0]      DEFAULT_PAT = 4'b1011
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             din_valid,
  input  logic             din,
  input  logic             overlap,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
  input  logic             count_clr,
  output logic             z,
  output logic [CNT_W-1:0] match_count
);

  // fill counts 0..PAT_W-1, so clog2(PAT_W) bits are always enough.
  localparam int unsigned             FILL_W   = $clog2(PAT_W);
  localparam logic [FILL_W-1:0]       FILL_MAX = FILL_W'(PAT_W - 1);
  localparam logic [CNT_W-1:0]        CNT_MAX  = '1;

  logic [PAT_W-1:0]  pat_q,   pat_d;
  logic [PAT_W-2:0]  hist_q,  hist_d;
  logic [FILL_W-1:0] fill_q,  fill_d;
  logic [CNT_W-1:0]  count_q, count_d;

  // Candidate window: the PAT_W-1 held bits followed by the incoming bit.
  // Its low PAT_W-1 bits are also the next history after a plain shift,
  // which keeps the shift legal even for PAT_W = 2.
  logic [PAT_W-1:0]  window;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned
    // (which would infer a latch).
    window  = {hist_q, din};
    pat_d   = pat_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    count_d = count_q;

    // Only a fully filled history may produce a match; stale or partial
    // history after reset / pattern load never fires.
    z = din_valid & ~pat_load & (fill_q == FILL_MAX) & (window == pat_q);

    if (pat_load) begin
      // A new pattern invalidates whatever history was collected.
      pat_d  = pat_in;
      hist_d = '0;
      fill_d = '0;
    end else if (din_valid) begin
      if (z && !overlap) begin
        // Non-overlapping: the matched bits are consumed, start afresh.
        hist_d = '0;
        fill_d = '0;
      end else begin
        hist_d = window[PAT_W-2:0];
        fill_d = (fill_q == FILL_MAX) ? FILL_MAX : fill_q + 1'b1;
      end
    end

    // A clear coinciding with a match leaves exactly that match counted.
    if (count_clr) begin
      count_d = z ? CNT_W'(1) : '0;
    end else if (z && (count_q != CNT_MAX)) begin
      count_d = count_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update
  // together from the values present before the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pat_q   <= DEFAULT_PAT;
      hist_q  <= '0;
      fill_q  <= '0;
      count_q <= '0;
    end else begin
      pat_q   <= pat_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      count_q <= count_d;
    end
  end

  assign match_count = count_q;

endmodule

// File: tb/tb_pattern_detector_param.sv
// -----------------------------------------------------------------------------
// tb_pattern_detector_param
//
// Directed bench for pattern_detector_param. Two instances share all inputs:
// the default configuration (CNT_W=8) and a narrow counter (CNT_W=2) used to
// observe saturation. Inputs change on the falling edge; z is sampled 1 ns
// later (same cycle, Mealy), registered outputs 1 ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_pattern_detector_param;

  logic       clk = 1'b0;
  logic       reset;
  logic       din_valid;
  logic       din;
  logic       overlap;
  logic       pat_load;
  logic [3:0] pat_in;
  logic       count_clr;
  logic       z;
  logic [7:0] match_count;
  logic       z2;
  logic [1:0] match_count2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pattern_detector_param #(.PAT_W(4), .CNT_W(8), .DEFAULT_PAT(4'b1011)) dut (
    .clk         (clk),
    .reset       (reset),
    .din_valid   (din_valid),
    .din         (din),
    .overlap     (overlap),
    .pat_load    (pat_load),
    .pat_in      (pat_in),
    .count_clr   (count_clr),
    .z           (z),
    .match_count (match_count)
  );

  pattern_detector_param #(.PAT_W(4), .CNT_W(2), .DEFAULT_PAT(4'b1011)) dut_narrow (
    .clk         (clk),
    .reset       (reset),
    .din_valid   (din_valid),
    .din         (din),
    .overlap     (overlap),
    .pat_load    (pat_load),
    .pat_in      (pat_in),
    .count_clr   (count_clr),
    .z           (z2),
    .match_count (match_count2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Present one bit on the falling edge and check z within that same cycle.
  task automatic send(input logic v, input logic d, input logic exp_z, input string tag);
    @(negedge clk);
    din_valid = v;
    din       = d;
    #1;
    check(tag, z, exp_z);
  endtask

  // Idle cycle, then check the registered counter.
  task automatic idle_check_count(input logic [7:0] exp_cnt, input string tag);
    @(negedge clk);
    din_valid = 1'b0;
    pat_load  = 1'b0;
    count_clr = 1'b0;
    #1;
    check(tag, match_count, exp_cnt);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset     = 1'b1;
    din_valid = 1'b0;
    pat_load  = 1'b0;
    count_clr = 1'b0;
    #1;
    check("rst_z", z, 1'b0);
    check("rst_cnt", match_count, 8'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    din_valid = 1'b0;
    din       = 1'b0;
    overlap   = 1'b1;
    pat_load  = 1'b0;
    pat_in    = 4'b0000;
    count_clr = 1'b0;

    // ---- Test 1: default 1011, overlapping ----
    do_reset();
    overlap = 1'b1;
    send(1, 1, 0, "t1_b1");
    send(1, 0, 0, "t1_b2");
    send(1, 1, 0, "t1_b3");
    send(1, 1, 1, "t1_b4");
    send(1, 0, 0, "t1_b5");
    send(1, 1, 0, "t1_b6");
    send(1, 1, 1, "t1_b7");
    idle_check_count(8'd2, "t1_count");

    // ---- Test 2: same stream, non-overlapping ----
    do_reset();
    overlap = 1'b0;
    send(1, 1, 0, "t2_b1");
    send(1, 0, 0, "t2_b2");
    send(1, 1, 0, "t2_b3");
    send(1, 1, 1, "t2_b4");
    send(1, 0, 0, "t2_b5");
    send(1, 1, 0, "t2_b6");
    send(1, 1, 0, "t2_b7");
    idle_check_count(8'd1, "t2_count");

    // ---- Test 3: invalid gaps hold state, z stays low with din=1 ----
    do_reset();
    overlap = 1'b1;
    send(1, 1, 0, "t3_b1");
    send(1, 0, 0, "t3_b2");
    send(1, 1, 0, "t3_b3");
    send(0, 1, 0, "t3_gap1");
    send(0, 1, 0, "t3_gap2");
    send(0, 1, 0, "t3_gap3");
    send(1, 1, 1, "t3_final");
    idle_check_count(8'd1, "t3_count");

    // ---- Test 4: pattern load wins over a would-be match, then 0000 ----
    do_reset();
    overlap = 1'b1;
    send(1, 1, 0, "t4_b1");
    send(1, 0, 0, "t4_b2");
    send(1, 1, 0, "t4_b3");
    @(negedge clk);
    pat_load  = 1'b1;
    pat_in    = 4'b0000;
    din_valid = 1'b1;
    din       = 1'b1;
    #1;
    check("t4_load_z", z, 1'b0);
    @(negedge clk);
    pat_load = 1'b0;
    din_valid = 1'b0;
    send(1, 0, 0, "t4_z1");
    send(1, 0, 0, "t4_z2");
    send(1, 0, 0, "t4_z3");
    send(1, 0, 1, "t4_z4");
    send(1, 0, 1, "t4_z5");
    send(1, 0, 1, "t4_z6");
    idle_check_count(8'd3, "t4_count");

    // ---- Test 5: reset mid-stream discards partial match ----
    do_reset();
    send(1, 1, 0, "t5_b1");
    send(1, 0, 0, "t5_b2");
    send(1, 1, 0, "t5_b3");
    do_reset();
    send(1, 1, 0, "t5_after1");
    send(1, 0, 0, "t5_after2");
    send(1, 1, 0, "t5_after3");
    send(1, 1, 1, "t5_after4");
    idle_check_count(8'd1, "t5_count");

    // ---- Test 6: 2-bit counter saturates, clear+match gives 1 ----
    do_reset();
    overlap = 1'b1;
    send(1, 1, 0, "t6_p0");
    send(1, 0, 0, "t6_p1");
    send(1, 1, 0, "t6_p2");
    for (int m = 0; m < 5; m++) begin
      logic [1:0] exp_c;
      exp_c = (m >= 2) ? 2'd3 : 2'(m + 1);
      if (m > 0) begin
        send(1, 0, 0, $sformatf("t6_m%0d_a", m));
        send(1, 1, 0, $sformatf("t6_m%0d_b", m));
      end
      send(1, 1, 1, $sformatf("t6_m%0d_z", m));
      @(posedge clk);
      #1;
      check($sformatf("t6_cnt_%0d", m), match_count2, exp_c);
    end
    send(1, 0, 0, "t6_c_a");
    send(1, 1, 0, "t6_c_b");
    @(negedge clk);
    din_valid = 1'b1;
    din       = 1'b1;
    count_clr = 1'b1;
    #1;
    check("t6_clr_z", z2, 1'b1);
    @(posedge clk);
    #1;
    check("t6_clr_match", match_count2, 2'd1);
    @(negedge clk);
    din_valid = 1'b0;
    count_clr = 1'b1;
    @(posedge clk);
    #1;
    check("t6_clr_only", match_count2, 2'd0);
    check("t6_wide_clr", match_count, 8'd0);
    @(negedge clk);
    count_clr = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
